mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, Busy duration in cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, Busy duration in cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  qualifies Op for one cycle; driven by the ID/EX start register.
REQ-006 SHALL have port Op  input  3  1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; other codes = no operation.
REQ-007 SHALL have port Cancel  input  1  exception/eret flush; suppresses the same-cycle Start.
REQ-008 SHALL have port A  input  32  rs operand; write data for mthi/mtlo.
REQ-009 SHALL have port B  input  32  rt operand.
REQ-010 SHALL have port Busy  output  1  operation in progress; the hazard unit stalls mult-type instructions in ID while Busy or Start is high.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.

Function
REQ-013 SHALL treat an accepted request as Start=1, Cancel=0, Busy=0 at a rising edge; any other Start SHALL be ignored.
REQ-014 SHALL, on an accepted mult/multu/div/divu, capture the result into pending registers at that edge, load the counter with MULT_CYCLES or DIV_CYCLES, and assert Busy from the next cycle.
REQ-015 SHALL decrement the counter once per cycle while Busy, keeping Busy high for exactly N cycles, where N is the loaded latency.
REQ-016 SHALL, on the edge where Busy falls, copy the pending results to HI/LO, so new HI/LO and Busy=0 become visible in the same cycle.
REQ-017 SHALL hold HI/LO at their prior values for the whole Busy period.
REQ-018 SHALL compute mult as a signed 32x32 to 64-bit product, with HI = bits 63:32 and LO = bits 31:0.
REQ-019 SHALL compute multu as an unsigned 32x32 to 64-bit product, with HI = bits 63:32 and LO = bits 31:0.
REQ-020 SHALL compute div as signed, with LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-021 SHALL compute divu as unsigned, with LO = quotient and HI = remainder.
REQ-022 SHALL, when B=0 on div/divu, still run the full Busy period but leave HI/LO unchanged at completion.
REQ-023 SHALL, on an accepted mthi/mtlo, write A to HI/LO at that edge, with no Busy and the other register untouched.
REQ-024 SHALL ignore mthi/mtlo presented while Busy=1.
REQ-025 SHALL ignore Cancel while Busy=1, so an in-flight operation always completes.
REQ-026 SHALL treat Start with an undefined Op code as a no-op.
REQ-027 SHALL produce a 0 to 1 transition on Busy exactly one cycle after the accepting edge, because back-to-back accepted starts are impossible.

Reset
REQ-028 SHALL, while reset=0, asynchronously force HI=0, LO=0, Busy=0, counter=0 and pending registers=0.
REQ-029 SHALL, when reset is asserted mid-operation, discard the operation; after release, HI/LO stay 0 and Busy stays 0.
REQ-030 SHALL accept a Start presented on the first edge after reset release.

Verification
REQ-031 SHALL cover: mult with A=FFFFFFFD, B=00000005 -> Busy high exactly 5 cycles, then HI=FFFFFFFF and LO=FFFFFFF1.
REQ-032 SHALL cover: multu with A=FFFFFFFF, B=00000002 -> HI=00000001 and LO=FFFFFFFE after 5 cycles, with HI/LO unchanged during Busy.
REQ-033 SHALL cover: div with A=FFFFFFF9 (-7), B=00000002 -> Busy high exactly 10 cycles, then LO=FFFFFFFD and HI=FFFFFFFF; divu with A=7, B=0 -> Busy high 10 cycles and HI/LO unchanged.
REQ-034 SHALL cover: Start with Op=mult and Cancel=1 -> Busy stays 0 and HI/LO unchanged; Start with Op=mthi, A=12345678 -> HI=12345678 next cycle, LO unchanged.
REQ-035 SHALL cover: mtlo with A=AAAA5555 while Busy -> ignored; the final LO equals the computed result.
REQ-036 SHALL cover: reset=0 at Busy cycle 3 of a div -> Busy=0 and HI=LO=0 immediately and after release; a new mult issued afterwards completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO unit: result computed at accept, committed to HI/LO
// when the fixed-latency Busy window closes. mthi/mtlo write immediately.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic        Cancel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             pend_ok_r;
   logic [31:0]      pend_hi_r;
   logic [31:0]      pend_lo_r;
   logic [31:0]      hi_r;
   logic [31:0]      lo_r;

   logic             accept_s;
   logic             b_nz_s;
   logic [31:0]      divisor_s;
   logic [63:0]      smul_s;
   logic [63:0]      umul_s;
   logic [31:0]      squo_s;
   logic [31:0]      srem_s;
   logic [31:0]      uquo_s;
   logic [31:0]      urem_s;
   logic [31:0]      res_hi_s;
   logic [31:0]      res_lo_s;
   logic             res_ok_s;
   logic             launch_s;
   logic [CNT_W-1:0] lat_s;

   assign accept_s  = Start & ~Cancel & ~busy_r;
   assign b_nz_s    = (B != 32'd0);
   // Divide by one when B is zero so the datapath never sees /0; the result is discarded anyway
   assign divisor_s = b_nz_s ? B : 32'd1;

   assign smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign umul_s = {32'd0, A} * {32'd0, B};
   assign squo_s = 32'($signed(A) / $signed(divisor_s));
   assign srem_s = 32'($signed(A) % $signed(divisor_s));
   assign uquo_s = A / divisor_s;
   assign urem_s = A % divisor_s;

   // Select result, commit enable and latency for the presented Op
   always_comb begin
      res_hi_s = 32'd0;
      res_lo_s = 32'd0;
      res_ok_s = 1'b0;
      launch_s = 1'b0;
      lat_s    = {CNT_W{1'b0}};
      case (Op)
         OP_MULT: begin
            res_hi_s = smul_s[63:32];
            res_lo_s = smul_s[31:0];
            res_ok_s = 1'b1;
            launch_s = 1'b1;
            lat_s    = MULT_LAT;
         end
         OP_MULTU: begin
            res_hi_s = umul_s[63:32];
            res_lo_s = umul_s[31:0];
            res_ok_s = 1'b1;
            launch_s = 1'b1;
            lat_s    = MULT_LAT;
         end
         OP_DIV: begin
            res_hi_s = srem_s;
            res_lo_s = squo_s;
            res_ok_s = b_nz_s;
            launch_s = 1'b1;
            lat_s    = DIV_LAT;
         end
         OP_DIVU: begin
            res_hi_s = urem_s;
            res_lo_s = uquo_s;
            res_ok_s = b_nz_s;
            launch_s = 1'b1;
            lat_s    = DIV_LAT;
         end
         default: begin
            res_ok_s = 1'b0;
            launch_s = 1'b0;
         end
      endcase
   end

   // Busy countdown, pending capture and HI/LO commit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r     <= {CNT_W{1'b0}};
         busy_r    <= 1'b0;
         pend_ok_r <= 1'b0;
         pend_hi_r <= 32'd0;
         pend_lo_r <= 32'd0;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
      end else if (busy_r) begin
         if (cnt_r <= CNT_W'(1)) begin
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            if (pend_ok_r) begin
               hi_r <= pend_hi_r;
               lo_r <= pend_lo_r;
            end else begin
               hi_r <= hi_r;
               lo_r <= lo_r;
            end
         end else begin
            cnt_r <= cnt_r - CNT_W'(1);
         end
      end else if (accept_s) begin
         if (launch_s) begin
            pend_hi_r <= res_hi_s;
            pend_lo_r <= res_lo_s;
            pend_ok_r <= res_ok_s;
            cnt_r     <= lat_s;
            busy_r    <= 1'b1;
         end else if (Op == OP_MTHI) begin
            hi_r <= A;
         end else if (Op == OP_MTLO) begin
            lo_r <= A;
         end else begin
            hi_r <= hi_r;
         end
      end else begin
         busy_r <= 1'b0;
      end
   end

   assign Busy = busy_r;
   assign HI   = hi_r;
   assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a deadline-based arithmetic model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_mult_div_unit;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [2:0]  Op;
   logic        Cancel;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   int          cyc = 0;
   int          busy_end = 0;
   logic        m_busy = 1'b0;
   logic        p_ok = 1'b0;
   logic [31:0] p_hi = 32'd0;
   logic [31:0] p_lo = 32'd0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Op(Op), .Cancel(Cancel),
      .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      m_busy = 1'b0; p_ok = 1'b0; p_hi = 32'd0; p_lo = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0; busy_end = 0;
   endtask

   task automatic launch(input logic [31:0] h, input logic [31:0] l, input logic ok, input int lat);
      p_hi = h; p_lo = l; p_ok = ok;
      m_busy = 1'b1;
      busy_end = cyc + lat;
   endtask

   task automatic model_edge();
      longint sa, sb, sp;
      longint unsigned ua, ub, up;
      int di, dd;
      cyc++;
      if (!reset) begin
         model_clear();
      end else if (m_busy) begin
         if (cyc == busy_end) begin
            m_busy = 1'b0;
            if (p_ok) begin m_hi = p_hi; m_lo = p_lo; end
         end
      end else if (Start && !Cancel) begin
         case (Op)
            OP_MULT: begin
               sa = $signed(A); sb = $signed(B); sp = sa * sb;
               launch(sp[63:32], sp[31:0], 1'b1, 5);
            end
            OP_MULTU: begin
               ua = A; ub = B; up = ua * ub;
               launch(up[63:32], up[31:0], 1'b1, 5);
            end
            OP_DIV: begin
               di = A; dd = B;
               if (dd == 0) launch(32'd0, 32'd0, 1'b0, 10);
               else launch(di % dd, di / dd, 1'b1, 10);
            end
            OP_DIVU: begin
               if (B == 32'd0) launch(32'd0, 32'd0, 1'b0, 10);
               else launch(A % B, A / B, 1'b1, 10);
            end
            OP_MTHI: m_hi = A;
            OP_MTLO: m_lo = A;
            default: ;
         endcase
      end
   endtask

   task automatic compare_all();
      chk("busy", {31'd0, Busy}, {31'd0, m_busy});
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
   endtask

   // One clock: model follows the edge, outputs are compared on the falling edge
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cn);
      Start = 1'b1; Op = op; A = a; B = b; Cancel = cn;
      step();
      Start = 1'b0; Cancel = 1'b0; Op = 3'd0;
   endtask

   // Count cycles Busy stays high, bounded
   task automatic count_busy(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 40) begin
         n++;
         step();
      end
   endtask

   int n;

   initial begin
      reset = 1'b0; Start = 1'b0; Op = 3'd0; Cancel = 1'b0; A = 32'd0; B = 32'd0;
      @(negedge clk);
      compare_all();
      chk("reset_hi", HI, 32'h0);
      chk("reset_busy", {31'd0, Busy}, 32'd0);

      // Start on the first edge after release
      reset = 1'b1;
      issue(OP_MULT, 32'hFFFFFFFD, 32'h00000005, 1'b0);
      count_busy(n);
      chk("mult_busy_cycles", 32'(n), 32'd5);
      chk("mult_hi", HI, 32'hFFFFFFFF);
      chk("mult_lo", LO, 32'hFFFFFFF1);

      issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0);
      step(); step();
      chk("multu_hold_hi", HI, 32'hFFFFFFFF);
      chk("multu_hold_lo", LO, 32'hFFFFFFF1);
      count_busy(n);
      chk("multu_busy_cycles", 32'(n + 2), 32'd5);
      chk("multu_hi", HI, 32'h00000001);
      chk("multu_lo", LO, 32'hFFFFFFFE);

      issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      count_busy(n);
      chk("div_busy_cycles", 32'(n), 32'd10);
      chk("div_lo", LO, 32'hFFFFFFFD);
      chk("div_hi", HI, 32'hFFFFFFFF);

      issue(OP_DIVU, 32'h00000007, 32'h00000000, 1'b0);
      count_busy(n);
      chk("divu0_busy_cycles", 32'(n), 32'd10);
      chk("divu0_hi", HI, 32'hFFFFFFFF);
      chk("divu0_lo", LO, 32'hFFFFFFFD);

      issue(OP_MULT, 32'h00000003, 32'h00000003, 1'b1);
      chk("cancel_busy", {31'd0, Busy}, 32'd0);
      step();
      chk("cancel_lo", LO, 32'hFFFFFFFD);

      issue(OP_MTHI, 32'h12345678, 32'h0, 1'b0);
      chk("mthi_hi", HI, 32'h12345678);
      chk("mthi_lo", LO, 32'hFFFFFFFD);

      // mtlo and a cancelled start while busy must both be ignored
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
      issue(OP_MTLO, 32'hAAAA5555, 32'h0, 1'b0);
      issue(OP_MULT, 32'd2, 32'd2, 1'b1);
      chk("mtlo_busy_lo", LO, 32'hFFFFFFFD);
      count_busy(n);
      chk("divu_busy_cycles", 32'(n + 2), 32'd10);
      chk("divu_lo", LO, 32'h0000000E);
      chk("divu_hi", HI, 32'h00000002);

      issue(3'd0, 32'hDEADBEEF, 32'h1, 1'b0);
      issue(3'd7, 32'hDEADBEEF, 32'h1, 1'b0);
      chk("undef_busy", {31'd0, Busy}, 32'd0);
      issue(OP_MTLO, 32'h0BADF00D, 32'h0, 1'b0);
      chk("mtlo_lo", LO, 32'h0BADF00D);

      issue(OP_DIV, 32'h00000007, 32'hFFFFFFFE, 1'b0);
      count_busy(n);
      chk("div_negb_lo", LO, 32'hFFFFFFFD);
      chk("div_negb_hi", HI, 32'h00000001);

      issue(OP_MULT, 32'h80000000, 32'h80000000, 1'b0);
      count_busy(n);
      chk("mult_min_hi", HI, 32'h40000000);
      chk("mult_min_lo", LO, 32'h00000000);

      // Reset during the third busy cycle of a divide
      issue(OP_DIV, 32'd50, 32'd3, 1'b0);
      step(); step();
      reset = 1'b0;
      model_clear();
      #1;
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_hi", HI, 32'h0);
      chk("rst_lo", LO, 32'h0);
      step(); step();
      @(negedge clk);
      reset = 1'b1;
      step(); step(); step(); step(); step(); step(); step(); step(); step(); step(); step();
      chk("post_rst_hi", HI, 32'h0);
      chk("post_rst_lo", LO, 32'h0);
      chk("post_rst_busy", {31'd0, Busy}, 32'd0);

      issue(OP_MULT, 32'd6, 32'd7, 1'b0);
      count_busy(n);
      chk("post_rst_mult_cycles", 32'(n), 32'd5);
      chk("post_rst_mult_lo", LO, 32'd42);
      chk("post_rst_mult_hi", HI, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
